hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall / flush / operand-forward control for a DOF-EX-WB pipeline.
// Define HAZARD_FORWARD_EN to forward EX/WB results and stall only on load-use hazards.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        dof_valid,
  input  logic [4:0]  dof_aa,
  input  logic [4:0]  dof_ba,
  input  logic        dof_ma,
  input  logic        dof_mb,
  input  logic        ex_valid,
  input  logic        ex_rw,
  input  logic [4:0]  ex_da,
  input  logic        ex_ld,
  input  logic        wb_valid,
  input  logic        wb_rw,
  input  logic [4:0]  wb_da,
  input  logic        br_taken,
  output logic        pc_hold,
  output logic        ir_hold,
  output logic        dof_bubble,
  output logic        if_flush,
  output logic        dof_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count,
  output logic        hazard_err
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] consec_stall;
  logic       match_ex_a;
  logic       match_ex_b;
  logic       match_wb_a;
  logic       match_wb_b;
  logic       stall_req;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  // Register 0 is hard-wired, so a zero source never matches a producer.
  assign match_ex_a = dof_valid & ~dof_ma & (dof_aa != 5'd0) & ex_valid & ex_rw & (ex_da == dof_aa);
  assign match_ex_b = dof_valid & ~dof_mb & (dof_ba != 5'd0) & ex_valid & ex_rw & (ex_da == dof_ba);
  assign match_wb_a = dof_valid & ~dof_ma & (dof_aa != 5'd0) & wb_valid & wb_rw & (wb_da == dof_aa);
  assign match_wb_b = dof_valid & ~dof_mb & (dof_ba != 5'd0) & wb_valid & wb_rw & (wb_da == dof_ba);

`ifdef HAZARD_FORWARD_EN
  // A load result is not ready in EX, so only that case still needs a stall.
  assign stall_req = (match_ex_a | match_ex_b) & ex_ld;
  assign fwd_a_sel = (match_ex_a & ~ex_ld) ? 2'b01 : (match_wb_a ? 2'b10 : 2'b00);
  assign fwd_b_sel = (match_ex_b & ~ex_ld) ? 2'b01 : (match_wb_b ? 2'b10 : 2'b00);
`else
  logic unused_ex_ld;
  assign unused_ex_ld = ex_ld;
  assign stall_req    = match_ex_a | match_ex_b | match_wb_a | match_wb_b;
  assign fwd_a_sel    = 2'b00;
  assign fwd_b_sel    = 2'b00;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a taken branch wins over any stall request.
  always_comb begin
    next_state = INIT;
    case (state)
      INIT:  next_state = RUN;
      RUN, STALL: begin
        if (br_taken) begin
          next_state = FLUSH;
        end else if (stall_req) begin
          next_state = STALL;
        end else begin
          next_state = RUN;
        end
      end
      FLUSH: next_state = RUN;
      default: next_state = INIT;
    endcase
  end

  // Control outputs; forwarding is only meaningful when DOF actually issues.
  always_comb begin
    pc_hold    = 1'b0;
    ir_hold    = 1'b0;
    dof_bubble = 1'b0;
    if_flush   = 1'b0;
    dof_flush  = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    case (state)
      INIT: begin
        if_flush  = 1'b1;
        dof_flush = 1'b1;
      end
      RUN, STALL: begin
        if (br_taken) begin
          if_flush  = 1'b1;
          dof_flush = 1'b1;
        end else if (stall_req) begin
          pc_hold    = 1'b1;
          ir_hold    = 1'b1;
          dof_bubble = 1'b1;
        end else begin
          fwd_a = fwd_a_sel;
          fwd_b = fwd_b_sel;
        end
      end
      FLUSH: begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
      end
      default: begin
        if_flush  = 1'b1;
        dof_flush = 1'b1;
      end
    endcase
  end

  // Saturating stall counter and sticky watchdog on four back-to-back stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count  <= 16'd0;
      consec_stall <= 2'd0;
      hazard_err   <= 1'b0;
    end else if (dof_bubble) begin
      if (stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
      if (consec_stall == 2'd3) begin
        hazard_err <= 1'b1;
      end else begin
        consec_stall <= consec_stall + 2'd1;
      end
    end else begin
      consec_stall <= 2'd0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        dof_valid, dof_ma, dof_mb;
  logic [4:0]  dof_aa, dof_ba;
  logic        ex_valid, ex_rw, ex_ld;
  logic [4:0]  ex_da;
  logic        wb_valid, wb_rw;
  logic [4:0]  wb_da;
  logic        br_taken;
  logic        pc_hold, ir_hold, dof_bubble, if_flush, dof_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;
  logic        hazard_err;

  int tests = 0;
  int fails = 0;

  // behavioural model: pipeline either just came out of reset, just took a branch, or is active
  bit       m_init, m_after_br, m_err;
  int       m_total, m_run;
  logic [8:0] e_ctl;
  bit       e_bubble;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .dof_valid(dof_valid), .dof_aa(dof_aa), .dof_ba(dof_ba), .dof_ma(dof_ma), .dof_mb(dof_mb),
    .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_da(ex_da), .ex_ld(ex_ld),
    .wb_valid(wb_valid), .wb_rw(wb_rw), .wb_da(wb_da),
    .br_taken(br_taken),
    .pc_hold(pc_hold), .ir_hold(ir_hold), .dof_bubble(dof_bubble),
    .if_flush(if_flush), .dof_flush(dof_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void predict();
    bit reads_a, reads_b, ex_w, wb_w, exa, exb, wba, wbb, req, active, flush, hold;
    logic [1:0] fa, fb;
    reads_a = dof_valid && !dof_ma && (dof_aa != 5'd0);
    reads_b = dof_valid && !dof_mb && (dof_ba != 5'd0);
    ex_w    = ex_valid && ex_rw;
    wb_w    = wb_valid && wb_rw;
    exa = reads_a && ex_w && (ex_da == dof_aa);
    exb = reads_b && ex_w && (ex_da == dof_ba);
    wba = reads_a && wb_w && (wb_da == dof_aa);
    wbb = reads_b && wb_w && (wb_da == dof_ba);
`ifdef HAZARD_FORWARD_EN
    req = (exa || exb) && ex_ld;
    fa  = (exa && !ex_ld) ? 2'b01 : (wba ? 2'b10 : 2'b00);
    fb  = (exb && !ex_ld) ? 2'b01 : (wbb ? 2'b10 : 2'b00);
`else
    req = exa || exb || wba || wbb;
    fa  = 2'b00;
    fb  = 2'b00;
`endif
    active = !m_init && !m_after_br;
    flush  = m_init || (active && br_taken);
    hold   = active && !br_taken && req;
    if (!(active && !br_taken && !req)) begin
      fa = 2'b00;
      fb = 2'b00;
    end
    e_ctl    = {hold, hold, hold, flush, flush, fa, fb};
    e_bubble = hold;
  endfunction

  function automatic void update();
    bit active;
    if (rst) begin
      m_init = 1'b1; m_after_br = 1'b0; m_total = 0; m_run = 0; m_err = 1'b0;
    end else begin
      if (e_bubble) begin
        if (m_total < 65535) m_total++;
        if (m_run >= 3) m_err = 1'b1;
        else m_run++;
      end else begin
        m_run = 0;
      end
      active     = !m_init && !m_after_br;
      m_after_br = active && br_taken;
      m_init     = 1'b0;
    end
  endfunction

  // inputs are stable from edge+1; compare at edge+5, then advance the model at the edge
  task automatic cycle(input string tag);
    #4;
    predict();
    chk({tag, " ctl"}, 16'({pc_hold, ir_hold, dof_bubble, if_flush, dof_flush, fwd_a, fwd_b}), 16'(e_ctl));
    chk({tag, " cnt"}, stall_count, 16'(m_total));
    chk({tag, " err"}, 16'(hazard_err), 16'(m_err));
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic clr_in();
    dof_valid = 1'b0; dof_aa = 5'd0; dof_ba = 5'd0; dof_ma = 1'b0; dof_mb = 1'b0;
    ex_valid = 1'b0; ex_rw = 1'b0; ex_da = 5'd0; ex_ld = 1'b0;
    wb_valid = 1'b0; wb_rw = 1'b0; wb_da = 5'd0; br_taken = 1'b0;
  endtask

  task automatic ex_haz(input logic [4:0] r, input logic ld);
    dof_valid = 1'b1; dof_aa = r; dof_ma = 1'b0;
    ex_valid = 1'b1; ex_rw = 1'b1; ex_da = r; ex_ld = ld;
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_init = 1'b1; m_after_br = 1'b0; m_total = 0; m_run = 0; m_err = 1'b0;
    cycle("rst_hold");
    rst = 1'b0;
    cycle("init_out");
    cycle("run_idle");

    // RAW on EX result (stalls without forwarding), then count visible
    ex_haz(5'd5, 1'b0);
    cycle("raw_ex");
    clr_in();
    cycle("after_raw");
    // PC_1 operand / register 0 do not create hazards
    ex_haz(5'd5, 1'b0); dof_ma = 1'b1;
    cycle("ma_sel");
    ex_haz(5'd0, 1'b0);
    cycle("reg0");
    clr_in();

    // branch coincident with a hazard, branch still high during FLUSH
    ex_haz(5'd9, 1'b1); br_taken = 1'b1;
    cycle("br_haz");
    cycle("flush_ign");
    br_taken = 1'b0;
    cycle("post_flush");
    clr_in();
    cycle("idle2");

    // B operand produced by both EX and WB; then load-use
    dof_valid = 1'b1; dof_ba = 5'd7; dof_mb = 1'b0;
    ex_valid = 1'b1; ex_rw = 1'b1; ex_da = 5'd7; ex_ld = 1'b0;
    wb_valid = 1'b1; wb_rw = 1'b1; wb_da = 5'd7;
    cycle("fwd_ex_b");
    ex_ld = 1'b1;
    cycle("ld_use");
    ex_valid = 1'b0; ex_ld = 1'b0;
    cycle("fwd_wb_b");
    dof_aa = 5'd7; dof_ma = 1'b0;
    cycle("wb_ab");
    clr_in();

    // randomized traffic over a small register range to make matches frequent
    for (int i = 0; i < 400; i++) begin
      dof_valid = 1'($urandom_range(1, 0)); dof_ma = ($urandom_range(3, 0) == 0);
      dof_mb = ($urandom_range(3, 0) == 0);
      dof_aa = 5'($urandom_range(3, 0)); dof_ba = 5'($urandom_range(3, 0));
      ex_valid = 1'($urandom_range(1, 0)); ex_rw = 1'($urandom_range(1, 0));
      ex_da = 5'($urandom_range(3, 0)); ex_ld = 1'($urandom_range(1, 0));
      wb_valid = 1'($urandom_range(1, 0)); wb_rw = 1'($urandom_range(1, 0));
      wb_da = 5'($urandom_range(3, 0));
      br_taken = ($urandom_range(7, 0) == 0);
      rst = ($urandom_range(49, 0) == 0);
      cycle("rand");
    end
    clr_in();
    rst = 1'b1;
    cycle("rst_again");
    rst = 1'b0;
    cycle("init2");

    // watchdog: four back-to-back stalls, sticky after the hazard clears
    ex_haz(5'd3, 1'b1);
    for (int i = 0; i < 4; i++) cycle("wd_stall");
    clr_in();
    cycle("wd_sticky");
    cycle("wd_sticky2");

    // long stall to drive the counter into saturation
    ex_haz(5'd4, 1'b1);
    for (int i = 0; i < 65540; i++) cycle("sat");
    // reset while stalled
    rst = 1'b1;
    cycle("rst_mid");
    cycle("rst_hold2");
    rst = 1'b0;
    clr_in();
    cycle("init3");
    cycle("run3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
